sccb_write_arbiter: RTL and testbench



---
 rtl/sccb_arb_pkg.sv | 38 +++
 rtl/sccb_arb_pick.sv | 61 ++++++
 rtl/sccb_write_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sccb_write_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sccb_arb_pkg
// Description : Shared types and helpers for the SCCB write arbiter: FSM
//               state encoding, a width helper and the default idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
package sccb_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT0 = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Default forced bus-idle time after each engine completion, in clk cycles
  localparam int c_DEFAULT_GAP_CYCLES = 64;

  // Bits needed to hold values 0..value-1, never less than one bit
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage : sccb_arb_pkg
`default_nettype wire

// File: rtl/sccb_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : sccb_arb_pick
// Description : Combinational winner selector for the SCCB write arbiter.
//               Default: round-robin search starting after 'pointer'.
//               With SCCB_ARB_FIXED_PRIO_EN defined: lowest index wins and
//               'pointer' is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_arb_pick
  import sccb_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDXW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] pointer,
  output logic            valid,
  output logic [IDXW-1:0] winner
);

`ifdef SCCB_ARB_FIXED_PRIO_EN

  // Pointer has no meaning when priority is fixed
  logic w_unused_pointer;
  assign w_unused_pointer = ^pointer;

  // Scan from the top down so the lowest set index is written last and wins
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid  = 1'b1;
        winner = IDXW'(i);
      end
    end
  end

`else

  logic [IDXW-1:0] w_idx;

  // Scan candidates farthest-first so the one nearest pointer+1 is written last
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    w_idx  = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = IDXW'((int'(pointer) + i) % NREQ);
      if (req[w_idx]) begin
        valid  = 1'b1;
        winner = w_idx;
      end
    end
  end

`endif

endmodule : sccb_arb_pick
`default_nettype wire

// File: rtl/sccb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sccb_write_arbiter
// Description : Shares a single SCCB register-write engine among NREQ
//               requesters. Latches the winner's index/value, pulses the
//               engine start, waits for completion, acks the requester and
//               enforces a GAP_CYCLES bus-idle interval before the next grant.
//               Build option SCCB_ARB_FIXED_PRIO_EN selects fixed priority
//               (lowest index first) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_write_arbiter
  import sccb_arb_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int REGI_MSB   = 15,
  parameter int GAP_CYCLES = c_DEFAULT_GAP_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*(REGI_MSB+1)-1:0] req_regi,
  input  logic [NREQ*8-1:0]            req_regv,
  output logic [NREQ-1:0]              ack,
  output logic                         busy,
  output logic [REGI_MSB:0]            eng_regi,
  output logic [7:0]                   eng_regv,
  output logic                         eng_start,
  input  logic                         eng_done
);

  localparam int c_IDXW = clog2(NREQ);
  localparam int c_GAPW = clog2(GAP_CYCLES + 1);
  localparam int c_RW   = REGI_MSB + 1;
  localparam logic [c_GAPW-1:0] c_GAP_LOAD = c_GAPW'(GAP_CYCLES);
  localparam logic [NREQ-1:0]   c_ACK_LSB  = NREQ'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_grant_en;
  logic              w_complete;
  logic              w_pick_valid;
  logic [c_IDXW-1:0] w_pick_idx;
  logic [c_IDXW-1:0] w_ptr;
  logic [c_IDXW-1:0] r_grant;
  logic [c_GAPW-1:0] r_gap_cnt;
  logic [NREQ-1:0]   r_ack;
  logic [REGI_MSB:0] r_eng_regi;
  logic [7:0]        r_eng_regv;
  logic [REGI_MSB:0] w_sel_regi;
  logic [7:0]        w_sel_regv;

  sccb_arb_pick #(
    .NREQ (NREQ),
    .IDXW (c_IDXW)
  ) u_pick (
    .req     (req),
    .pointer (w_ptr),
    .valid   (w_pick_valid),
    .winner  (w_pick_idx)
  );

`ifdef SCCB_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  localparam logic [c_IDXW-1:0] c_PTR_RESET = c_IDXW'(NREQ - 1);
  logic [c_IDXW-1:0] r_ptr;

  // Round-robin pointer follows the last requester that completed a write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= c_PTR_RESET;
    end else if (w_complete) begin
      r_ptr <= r_grant;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // Mux the winning requester's register index and value
  always_comb begin
    w_sel_regi = '0;
    w_sel_regv = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_pick_idx == c_IDXW'(k)) begin
        w_sel_regi = req_regi[k*c_RW +: c_RW];
        w_sel_regv = req_regv[k*8 +: 8];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state plus grant/complete strobes for the datapath
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant_en  = 1'b1;
          w_state_nxt = START;
        end
      end
      START: w_state_nxt = WAIT0;
      // The engine needs a cycle to drop its done level after start
      WAIT0: w_state_nxt = WAIT;
      WAIT: begin
        if (eng_done) begin
          w_complete  = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant latch, ack pulse and bus-idle gap counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant    <= '0;
      r_eng_regi <= '0;
      r_eng_regv <= '0;
      r_ack      <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_ack <= '0;
      if (w_grant_en) begin
        r_grant    <= w_pick_idx;
        r_eng_regi <= w_sel_regi;
        r_eng_regv <= w_sel_regv;
      end
      if (w_complete) begin
        r_ack     <= c_ACK_LSB << r_grant;
        r_gap_cnt <= c_GAP_LOAD;
      end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - c_GAPW'(1);
      end
    end
  end

  assign ack       = r_ack;
  assign busy      = (r_state != IDLE);
  assign eng_start = (r_state == START);
  assign eng_regi  = r_eng_regi;
  assign eng_regv  = r_eng_regv;

endmodule : sccb_write_arbiter
`default_nettype wire

// File: tb/tb_sccb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sccb_write_arbiter
// Description : Directed self-checking bench for sccb_write_arbiter, with a
//               behavioural SCCB engine model per instance. One instance uses
//               the default 64-cycle gap, a second uses a zero gap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [2:0]  req, req0;
  logic [47:0] req_regi, req_regi0;
  logic [23:0] req_regv, req_regv0;
  logic [2:0]  ack, ack0;
  logic        busy, busy0;
  logic [15:0] eng_regi, eng_regi0;
  logic [7:0]  eng_regv, eng_regv0;
  logic        eng_start, eng_start0;
  logic        eng_done, eng_done0;

  int eng_len, eng_cnt, eng0_len, eng0_cnt;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sccb_write_arbiter #(.NREQ(3), .REGI_MSB(15), .GAP_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .req(req), .req_regi(req_regi), .req_regv(req_regv),
    .ack(ack), .busy(busy), .eng_regi(eng_regi), .eng_regv(eng_regv),
    .eng_start(eng_start), .eng_done(eng_done)
  );

  sccb_write_arbiter #(.NREQ(3), .REGI_MSB(15), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .req_regi(req_regi0), .req_regv(req_regv0),
    .ack(ack0), .busy(busy0), .eng_regi(eng_regi0), .eng_regv(eng_regv0),
    .eng_start(eng_start0), .eng_done(eng_done0)
  );

  // Engine model: done drops after start, stays low eng_len cycles, then rises
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_done <= 1'b1;
      eng_cnt  <= 0;
    end else if (eng_start) begin
      eng_done <= 1'b0;
      eng_cnt  <= eng_len;
    end else if (eng_cnt == 1) begin
      eng_done <= 1'b1;
      eng_cnt  <= 0;
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_done0 <= 1'b1;
      eng0_cnt  <= 0;
    end else if (eng_start0) begin
      eng_done0 <= 1'b0;
      eng0_cnt  <= eng0_len;
    end else if (eng0_cnt == 1) begin
      eng_done0 <= 1'b1;
      eng0_cnt  <= 0;
    end else if (eng0_cnt > 1) begin
      eng0_cnt <= eng0_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int maxc, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (eng_start !== 1'b1 && cyc < maxc);
  endtask

  task automatic wait_ack(input int maxc, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (ack === 3'b000 && cyc < maxc);
  endtask

  task automatic wait_idle(input int maxc);
    int cyc;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (busy !== 1'b0 && cyc < maxc);
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_start0(input int maxc, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (eng_start0 !== 1'b1 && cyc < maxc);
  endtask

  task automatic wait_ack0(input int maxc, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (ack0 === 3'b000 && cyc < maxc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int cyc2;
    int exp_idx;
    int exp_second;
    int exp_third;

    req = '0; req_regi = '0; req_regv = '0;
    req0 = '0; req_regi0 = '0; req_regv0 = '0;
    eng_len = 40; eng0_len = 5;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", {29'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, eng_start}, 32'd0);
    chk("rst_regi", {16'd0, eng_regi}, 32'd0);
    chk("rst_regv", {24'd0, eng_regv}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single write from requester 1, engine busy for 40 cycles
    req_regi[31:16] = 16'h3820;
    req_regv[15:8]  = 8'h47;
    req = 3'b010;
    chk("single_start_c0", {31'd0, eng_start}, 32'd0);
    @(negedge clk);
    chk("single_start_c1", {31'd0, eng_start}, 32'd1);
    chk("single_regi", {16'd0, eng_regi}, 32'h3820);
    chk("single_regv", {24'd0, eng_regv}, 32'h47);
    chk("single_busy", {31'd0, busy}, 32'd1);
    wait_ack(100, cyc);
    chk("single_req_to_ack", cyc + 1, 32'd43);
    chk("single_ack", {29'd0, ack}, 32'b010);
    req = 3'b000;
    @(negedge clk);
    chk("single_ack_pulse", {29'd0, ack}, 32'd0);
    repeat (63) @(negedge clk);
    chk("single_busy_gap_end", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("single_busy_low", {31'd0, busy}, 32'd0);

    // Contention with all three requesting continuously
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    eng_len = 8;
    req_regi = {16'h1002, 16'h1001, 16'h1000};
    req_regv = {8'h22, 8'h11, 8'h00};
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
`ifdef SCCB_ARB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = i % 3;
`endif
      wait_start(200, cyc);
      chk("rr_start", {31'd0, eng_start}, 32'd1);
      chk("rr_spacing", cyc, (i == 0) ? 32'd1 : 32'd66);
      chk("rr_regi", {16'd0, eng_regi}, 32'h1000 + exp_idx);
      wait_ack(50, cyc);
      chk("rr_start_to_ack", cyc, 32'd10);
      chk("rr_ack", {29'd0, ack}, 32'd1 << exp_idx);
      if (i == 5) req = 3'b000;
    end
    wait_idle(100);

    // Requester 0 arrives while requester 1 is being served
`ifdef SCCB_ARB_FIXED_PRIO_EN
    exp_second = 0; exp_third = 2;
`else
    exp_second = 2; exp_third = 0;
`endif
    req = 3'b110;
    wait_start(20, cyc);
    chk("late_first_spacing", cyc, 32'd1);
    chk("late_first_regi", {16'd0, eng_regi}, 32'h1001);
    repeat (3) @(negedge clk);
    req[0] = 1'b1;
    wait_ack(50, cyc);
    chk("late_first_ack", {29'd0, ack}, 32'b010);
    req[1] = 1'b0;
    wait_start(200, cyc);
    chk("late_second_spacing", cyc, 32'd66);
    chk("late_second_regi", {16'd0, eng_regi}, 32'h1000 + exp_second);
    wait_ack(50, cyc);
    chk("late_second_ack", {29'd0, ack}, 32'd1 << exp_second);
    req[exp_second] = 1'b0;
    wait_start(200, cyc);
    chk("late_third_regi", {16'd0, eng_regi}, 32'h1000 + exp_third);
    wait_ack(50, cyc);
    chk("late_third_ack", {29'd0, ack}, 32'd1 << exp_third);
    req = 3'b000;
    wait_idle(100);

    // Value latched at grant is immune to later input changes
    req_regv[7:0] = 8'h07;
    req = 3'b001;
    wait_start(20, cyc);
    chk("latch_regv_grant", {24'd0, eng_regv}, 32'h07);
    repeat (3) @(negedge clk);
    req_regv[7:0] = 8'h00;
    @(negedge clk);
    chk("latch_regv_wait", {24'd0, eng_regv}, 32'h07);
    wait_ack(50, cyc);
    chk("latch_regv_ack", {24'd0, eng_regv}, 32'h07);
    req = 3'b000;
    wait_idle(100);
    req = 3'b001;
    wait_start(20, cyc);
    chk("latch_regv_next", {24'd0, eng_regv}, 32'h00);
    wait_ack(50, cyc);
    req = 3'b000;
    wait_idle(100);

    // Reset while waiting on the engine
    req = 3'b100;
    wait_start(20, cyc);
    chk("mid_rst_pre_regi", {16'd0, eng_regi}, 32'h1002);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ack", {29'd0, ack}, 32'd0);
    chk("mid_rst_start", {31'd0, eng_start}, 32'd0);
    chk("mid_rst_regi", {16'd0, eng_regi}, 32'd0);
    chk("mid_rst_regv", {24'd0, eng_regv}, 32'd0);
    @(negedge clk);
    chk("mid_rst_ack_held", {29'd0, ack}, 32'd0);
    reset = 1'b0;
    wait_start(20, cyc);
    chk("post_rst_spacing", cyc, 32'd1);
    chk("post_rst_regi", {16'd0, eng_regi}, 32'h1002);
    wait_ack(50, cyc);
    chk("post_rst_ack", {29'd0, ack}, 32'b100);
    req = 3'b000;
    wait_idle(100);

    // Zero gap, requester 0 held: start-to-start is engine time + 4
    req_regi0[15:0] = 16'h3503;
    req_regv0[7:0]  = 8'h01;
    req0 = 3'b001;
    wait_start0(20, cyc);
    chk("b2b_first_start", cyc, 32'd1);
    wait_ack0(30, cyc);
    chk("b2b_start_to_ack", cyc, 32'd7);
    chk("b2b_ack", {29'd0, ack0}, 32'b001);
    wait_start0(30, cyc2);
    chk("b2b_spacing_1", cyc + cyc2, 32'd9);
    wait_start0(30, cyc);
    chk("b2b_spacing_2", cyc, 32'd9);
    req0 = 3'b000;
    wait_ack0(30, cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (busy0 !== 1'b0 && cyc < 20);
    chk("b2b_idle", {31'd0, busy0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sccb_write_arbiter
`default_nettype wire
